test_status_monitor: RTL

//  Synthesizable successor of the bench-side pass/fail check for riscv-tests runs.

---
 rtl/test_mon_pkg.sv | 21 ++
 rtl/sat_counter.sv | 29 ++
 rtl/test_status_monitor.sv | 114 +++++++++++
 3 files changed

// File: rtl/test_mon_pkg.sv
// Shared definitions for the riscv-tests status monitor.
// Holds the FSM state encoding, default watched register indices and settle delay.
// Imported by the monitor top; the state values are visible on state_o.
package test_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_PASS    = 3'd3,
    ST_FAIL    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_t;

  // riscv-tests convention: gp holds the test number, s10 the done flag, s11 the pass flag
  localparam int DEF_TESTNUM_REG   = 3;
  localparam int DEF_DONE_REG      = 26;
  localparam int DEF_PASS_REG      = 27;
  localparam int DEF_SETTLE_CYCLES = 10;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and count enable that sticks at all-ones.
// Latency: count visible one cycle after the enabled cycle.
// No backpressure; clear has priority over enable.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // count up while enabled, never wrapping past all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/test_status_monitor.sv
// Snoops regfile writes and turns the riscv-tests gp/s10/s11 protocol into a PASS/FAIL/TIMEOUT verdict.
// Latency: verdict visible SETTLE_CYCLES+1 cycles after the done write; outputs come from registered state.
// No backpressure; the snoop port is observe-only and every write is seen.
module test_status_monitor
  import test_mon_pkg::*;
#(
  parameter int          DATA_W         = 32,
  parameter int          ADDR_W         = 5,
  parameter int          TESTNUM_REG    = DEF_TESTNUM_REG,
  parameter int          DONE_REG       = DEF_DONE_REG,
  parameter int          PASS_REG       = DEF_PASS_REG,
  parameter int          SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int          CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [2:0]        state_o,
  output logic [DATA_W-1:0] testnum_o,
  output logic [CNT_W-1:0]  cycles_o
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  // Timeout fires on the edge where the cycle counter becomes TIMEOUT_CYCLES-1,
  // so timeout_o and cycles_o==TIMEOUT_CYCLES-1 appear together.
  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT_CYCLES) - (CNT_W+1)'(1);

  state_t            r_state;
  logic [DATA_W-1:0] r_testnum;
  logic              r_pass;
  logic [SW-1:0]     r_settle_cnt;

  logic              w_wr;
  logic              w_wr_done;
  logic              w_wr_pass;
  logic              w_wr_tnum;
  logic              w_pass_now;
  logic              w_live;
  logic              w_to_hit;
  logic [CNT_W-1:0]  w_cycles;
  logic [CNT_W:0]    w_cyc_next;

  assign w_wr       = we_i && (waddr_i != '0);
  assign w_wr_done  = w_wr && (waddr_i == ADDR_W'(DONE_REG)) && (wdata_i == DATA_W'(1));
  assign w_wr_pass  = w_wr && (waddr_i == ADDR_W'(PASS_REG));
  assign w_wr_tnum  = w_wr && (waddr_i == ADDR_W'(TESTNUM_REG));
  // pass flag as it stands this cycle, including a same-cycle write
  assign w_pass_now = w_wr_pass ? (wdata_i == DATA_W'(1)) : r_pass;
  assign w_live     = (r_state == ST_RUN) || (r_state == ST_SETTLE);
  assign w_cyc_next = {1'b0, w_cycles} + (CNT_W+1)'(1);
  assign w_to_hit   = (TIMEOUT_CYCLES != 0) && (w_cyc_next >= TO_LIM);

  sat_counter #(.CNT_W(CNT_W)) u_cycles (
    .clk   (clk),
    .rst   (rst),
    .i_clr (!en_i),
    .i_en  (en_i && w_live),
    .o_cnt (w_cycles)
  );

  // verdict FSM plus the shadow registers it samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_testnum    <= '0;
      r_pass       <= 1'b0;
      r_settle_cnt <= '0;
    end else if (!en_i) begin
      r_state      <= ST_IDLE;
      r_testnum    <= '0;
      r_pass       <= 1'b0;
      r_settle_cnt <= '0;
    end else begin
      // test number freezes once a verdict is reached
      if (w_live && w_wr_tnum) r_testnum <= wdata_i;
      if ((r_state != ST_IDLE) && w_wr_pass) r_pass <= (wdata_i == DATA_W'(1));
      case (r_state)
        ST_IDLE: r_state <= ST_RUN;
        ST_RUN: begin
          // done write beats a simultaneous watchdog expiry
          if (w_wr_done) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
          end else if (w_to_hit) begin
            r_state <= ST_TIMEOUT;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) r_state <= w_pass_now ? ST_PASS : ST_FAIL;
          else r_settle_cnt <= r_settle_cnt + SW'(1);
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign state_o   = r_state;
  assign pass_o    = (r_state == ST_PASS);
  assign fail_o    = (r_state == ST_FAIL);
  assign timeout_o = (r_state == ST_TIMEOUT);
  assign done_o    = pass_o || fail_o || timeout_o;
  assign testnum_o = r_testnum;
  assign cycles_o  = w_cycles;

endmodule
